fsab_sim_mem_v2: RTL
====================

// Module: fsab_sim_mem_v2
// PURPOSE
//   Parametrised behavioural FSAB slave memory for simulation. It accepts FSAB read and write bursts on fsabo,
//   returns read data on fsabi, and returns one credit for every request it retires.
//   Adds over the previous sim memory: configurable widths and depth, programmable read latency,
//   gap-free back-to-back requests, address wrap, and sticky protocol-error flags.
//   Sits at the bottom of the FSAB arbiter tree in all system testbenches.
// PARAMETERS
//   DATA_W     64        data bus width in bits; power of two, >=8; mask width is DATA_W/8
//   ADDR_W     31        byte-address width
//   LEN_W      4         burst length field width
//   LEN_MAX    8         largest legal burst in beats; must be <= 2**LEN_W-1
//   DID_W      4         width of the did and subdid fields
//   CREDITS    4         request FIFO depth; this is also the master's initial credit count
//   MEM_BYTES  8388608   backing store size in bytes; power of two
//   READ_LAT   2         idle cycles between a read request leaving the FIFO and its first fsabi beat (0..15)
// PORTS
//   clk            in   1          clock
//   Nrst           in   1          asynchronous reset, active-low
//   fsabo_valid    in   1          request or data beat valid
//   fsabo_mode     in   1          0 = read, 1 = write (FSAB_READ / FSAB_WRITE)
//   fsabo_did      in   DID_W      requester device id
//   fsabo_subdid   in   DID_W      requester sub-id
//   fsabo_addr     in   ADDR_W     byte address of the first beat
//   fsabo_len      in   LEN_W      burst length in beats
//   fsabo_data     in   DATA_W     write data
//   fsabo_mask     in   DATA_W/8   byte enables, 1 = write the byte
//   fsabo_credit   out  1          one-cycle pulse; returns one credit
//   fsabi_valid    out  1          read data beat valid
//   fsabi_did      out  DID_W      did of the read being returned
//   fsabi_subdid   out  DID_W      subdid of the read being returned
//   fsabi_data     out  DATA_W     read data
//   err_overflow   out  1          sticky: a request arrived with CREDITS requests already queued
//   err_len        out  1          sticky: a request arrived with len==0 or len>LEN_MAX
// BEHAVIOUR
//   Reset: all FIFO pointers, the FSM and the error flags clear; all outputs are 0; memory contents are preserved.
//   Inbound framing:
//     - A request's header is the first fsabo_valid beat after the previous burst has completed.
//     - A write is len consecutive-valid beats; data and mask are taken from every beat, including the header beat.
//     - A read is the header beat only.
//     - Non-valid cycles may occur inside a write burst; the beat count continues across them.
//   Request FIFO (RFIF): depth CREDITS; holds {mode, did, subdid, addr, len}.
//     - Push on the header beat.
//     - Push while full sets err_overflow and drops the request.
//   Data FIFO (DFIF): depth CREDITS*LEN_MAX; holds {data, mask}.
//     - Push on every write beat; a read never pushes.
//   Credit: fsabo_credit pulses in the cycle an RFIF entry is popped, so at most one pulse per cycle.
//   FSM: IDLE -> (pop) -> WAIT_W | LAT -> XFER -> IDLE, or -> the next popped request.
//     IDLE:
//       - Pop when RFIF is non-empty.
//       - Illegal len: pop, set err_len, discard any DFIF beats already received, stay in IDLE.
//     WAIT_W: hold until DFIF occupancy >= len, then go to XFER.
//       - A write therefore commits atomically, and only after all of its beats have arrived.
//     LAT: count READ_LAT cycles, then go to XFER. With READ_LAT=0, XFER follows the pop cycle directly.
//     XFER: one beat per cycle, len beats.
//       - Write: pop DFIF; byte i of the word is replaced when mask[i]=1.
//       - Read: drive fsabi_valid=1, the request's did/subdid, and the word.
//       - Last beat with RFIF non-empty: pop the next request in the same cycle, so there is no idle gap.
//   Addressing:
//     - word index = (addr >> log2(DATA_W/8)) mod (MEM_BYTES*8/DATA_W).
//     - Address bits below the word size are ignored.
//     - The index increments by 1 per beat and wraps at the end of memory.
//   Ordering: requests complete strictly in arrival order, so a read issued after a write returns the new data.
//   Unwritten memory reads as X. fsabi_data is X-free whenever fsabi_valid=1 and the word has been written.
//   Latency: a read header at cycle t, with the FSM idle, gives its first fsabi_valid at t+2+READ_LAT
//     (one cycle for the RFIF push, one for the pop).
//   Assertions ($error): DFIF overflow; a write with len>LEN_MAX; fsabi_valid=1 with X in did.
// TESTING
//   1. Reset, then write len=4 at 0x100 with data 1..4, mask all-ones, then read len=4 at 0x100
//      -> fsabi returns 1,2,3,4 on consecutive cycles; exactly 2 credit pulses.
//   2. Write 0xFFFF_FFFF_FFFF_FFFF to word 0x40, then write 0 with mask 8'h0F, then read
//      -> data 0xFFFF_FFFF_0000_0000.
//   3. READ_LAT=3: read header at cycle 10 with the FSM idle -> first fsabi_valid at cycle 15.
//   4. Five headers issued while no credits are returned, with CREDITS=4
//      -> err_overflow=1; the first four requests still complete.
//   5. Read len=2 at byte address MEM_BYTES-8 -> beats come from the last word, then word 0.
//   6. Nrst asserted mid-burst during a read
//      -> fsabi_valid=0 the same cycle; after release, a new read returns the earlier memory contents intact.

Source files
------------

// File: rtl/fsab_sim_mem_v2.sv
// fsab_sim_mem_v2: behavioural FSAB slave memory; queues requests, commits write bursts, returns read bursts and credits.
// Latency: read header at t with the FSM idle -> first fsabi beat at t+2+READ_LAT; a write commits once all its beats are queued.
// Backpressure: none on fsabo; the master must honour credits. A request arriving with the request queue full is dropped
//   and flags err_overflow.
// Ports: clk/Nrst; fsabo_* inbound header/data beats; fsabo_credit one pulse per retired request;
//   fsabi_* read data beats with the requester's did/subdid; err_overflow/err_len sticky protocol flags.

// fsab_mem_fifo: generic synchronous FIFO with occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: a push while full is ignored; a pop while empty is ignored.
module fsab_mem_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       Nrst,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    do_push  = push_vld && !full;
    do_pop   = pop_vld && !empty;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = store[rd_ptr_q];
  assign cnt      = cnt_q;
endmodule

module fsab_sim_mem_v2 #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 31,
  parameter int LEN_W     = 4,
  parameter int LEN_MAX   = 8,
  parameter int DID_W     = 4,
  parameter int CREDITS   = 4,
  parameter int MEM_BYTES = 8388608,
  parameter int READ_LAT  = 2
) (
  input  logic                clk,
  input  logic                Nrst,
  input  logic                fsabo_valid,
  input  logic                fsabo_mode,
  input  logic [DID_W-1:0]    fsabo_did,
  input  logic [DID_W-1:0]    fsabo_subdid,
  input  logic [ADDR_W-1:0]   fsabo_addr,
  input  logic [LEN_W-1:0]    fsabo_len,
  input  logic [DATA_W-1:0]   fsabo_data,
  input  logic [DATA_W/8-1:0] fsabo_mask,
  output logic                fsabo_credit,
  output logic                fsabi_valid,
  output logic [DID_W-1:0]    fsabi_did,
  output logic [DID_W-1:0]    fsabi_subdid,
  output logic [DATA_W-1:0]   fsabi_data,
  output logic                err_overflow,
  output logic                err_len
);
  localparam int MASK_W   = DATA_W / 8;
  localparam int OFF_W    = $clog2(MASK_W);
  localparam int WORDS    = MEM_BYTES / MASK_W;
  localparam int IDX_W    = $clog2(WORDS);
  localparam int DF_DEPTH = CREDITS * LEN_MAX;
  localparam int DF_CW    = $clog2(DF_DEPTH + 1);
  localparam int RF_CW    = $clog2(CREDITS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX_L = LEN_W'(LEN_MAX);

  typedef struct packed {
    logic              mode;
    logic [DID_W-1:0]  did;
    logic [DID_W-1:0]  subdid;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wbeat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_W, ST_LAT, ST_XFER} state_t;

  // Byte address -> word index; the cast drops the bits beyond the end of memory so indices wrap.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem [WORDS];

  // Inbound framing
  logic             in_wr_q, in_wr_d;
  logic [LEN_W-1:0] in_rem_q, in_rem_d;
  logic             in_keep_q, in_keep_d;
  logic             hdr_vld, hdr_len_ok;
  logic             df_push;
  logic             err_overflow_q, err_overflow_d;
  logic             err_len_q, err_len_d;

  // FIFOs
  req_t             rf_in, rf_head;
  logic             rf_pop, rf_full, rf_empty;
  logic [RF_CW-1:0] unused_rf_cnt;
  wbeat_t           df_in, df_head;
  logic             df_pop, df_full, unused_df_empty;
  logic [DF_CW-1:0] df_cnt;

  // Retire FSM
  state_t           state_q, state_d;
  logic             cur_mode_q, cur_mode_d;
  logic [DID_W-1:0] cur_did_q, cur_did_d;
  logic [DID_W-1:0] cur_subdid_q, cur_subdid_d;
  logic [LEN_W-1:0] cur_rem_q, cur_rem_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [3:0]       lat_q, lat_d;
  logic             mem_we, rd_vld;

  assign rf_in = {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len};
  assign df_in = {fsabo_data, fsabo_mask};

  // The first valid beat outside a write burst is a header. Beats of a dropped or illegal-length
  // write are consumed here but never queued, so the DFIF only ever holds committable data and the
  // FSM has nothing to discard when it rejects the request.
  always_comb begin
    in_wr_d        = in_wr_q;
    in_rem_d       = in_rem_q;
    in_keep_d      = in_keep_q;
    df_push        = 1'b0;
    hdr_vld        = fsabo_valid && !in_wr_q;
    hdr_len_ok     = (fsabo_len != '0) && (fsabo_len <= LEN_MAX_L);
    err_overflow_d = err_overflow_q | (hdr_vld && rf_full);
    if (hdr_vld && fsabo_mode) begin
      df_push = !rf_full && hdr_len_ok;
      if (fsabo_len > LEN_W'(1)) begin
        in_wr_d   = 1'b1;
        in_rem_d  = fsabo_len - LEN_W'(1);
        in_keep_d = df_push;
      end
    end else if (fsabo_valid && in_wr_q) begin
      df_push  = in_keep_q;
      in_rem_d = in_rem_q - LEN_W'(1);
      if (in_rem_q == LEN_W'(1)) begin
        in_wr_d = 1'b0;
      end
    end
  end

  fsab_mem_fifo #(.W($bits(req_t)), .DEPTH(CREDITS)) u_rfif (
    .clk      (clk),
    .Nrst     (Nrst),
    .push_vld (hdr_vld),
    .push_dat (rf_in),
    .pop_vld  (rf_pop),
    .head_dat (rf_head),
    .cnt      (unused_rf_cnt),
    .full     (rf_full),
    .empty    (rf_empty)
  );

  fsab_mem_fifo #(.W($bits(wbeat_t)), .DEPTH(DF_DEPTH)) u_dfif (
    .clk      (clk),
    .Nrst     (Nrst),
    .push_vld (df_push),
    .push_dat (df_in),
    .pop_vld  (df_pop),
    .head_dat (df_head),
    .cnt      (df_cnt),
    .full     (df_full),
    .empty    (unused_df_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    cur_did_d    = cur_did_q;
    cur_subdid_d = cur_subdid_q;
    cur_rem_d    = cur_rem_q;
    widx_d       = widx_q;
    lat_d        = lat_q;
    err_len_d    = err_len_q;
    rf_pop       = 1'b0;
    df_pop       = 1'b0;
    mem_we       = 1'b0;
    rd_vld       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rf_pop = !rf_empty;
      end
      ST_WAIT_W: begin
        // This write's beats are the oldest in the DFIF, so occupancy >= len means all have arrived.
        if (int'(df_cnt) >= int'(cur_rem_q)) begin
          state_d = ST_XFER;
        end
      end
      ST_LAT: begin
        if (lat_q == '0) begin
          state_d = ST_XFER;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_XFER: begin
        if (cur_mode_q) begin
          df_pop = 1'b1;
          mem_we = 1'b1;
        end else begin
          rd_vld = 1'b1;
        end
        widx_d    = widx_q + IDX_W'(1);
        cur_rem_d = cur_rem_q - LEN_W'(1);
        if (cur_rem_q == LEN_W'(1)) begin
          state_d = ST_IDLE;
          rf_pop  = !rf_empty;   // chain straight into the next request
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rf_pop) begin
      if ((rf_head.len == '0) || (rf_head.len > LEN_MAX_L)) begin
        err_len_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cur_mode_d   = rf_head.mode;
        cur_did_d    = rf_head.did;
        cur_subdid_d = rf_head.subdid;
        cur_rem_d    = rf_head.len;
        widx_d       = word_idx(rf_head.addr);
        if (rf_head.mode) begin
          state_d = ST_WAIT_W;
        end else if (READ_LAT == 0) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_LAT;
          lat_d   = 4'(READ_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      in_wr_q        <= 1'b0;
      in_rem_q       <= '0;
      in_keep_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      err_len_q      <= 1'b0;
      state_q        <= ST_IDLE;
      cur_mode_q     <= 1'b0;
      cur_did_q      <= '0;
      cur_subdid_q   <= '0;
      cur_rem_q      <= '0;
      widx_q         <= '0;
      lat_q          <= '0;
    end else begin
      in_wr_q        <= in_wr_d;
      in_rem_q       <= in_rem_d;
      in_keep_q      <= in_keep_d;
      err_overflow_q <= err_overflow_d;
      err_len_q      <= err_len_d;
      state_q        <= state_d;
      cur_mode_q     <= cur_mode_d;
      cur_did_q      <= cur_did_d;
      cur_subdid_q   <= cur_subdid_d;
      cur_rem_q      <= cur_rem_d;
      widx_q         <= widx_d;
      lat_q          <= lat_d;
    end
  end

  // Backing store has no reset so its contents survive Nrst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (df_head.mask[i]) begin
          mem[widx_q][i*8 +: 8] <= df_head.data[i*8 +: 8];
        end
      end
    end
  end

  assign fsabo_credit = rf_pop;
  assign fsabi_valid  = rd_vld;
  assign fsabi_did    = rd_vld ? cur_did_q : '0;
  assign fsabi_subdid = rd_vld ? cur_subdid_q : '0;
  assign fsabi_data   = rd_vld ? mem[widx_q] : '0;
  assign err_overflow = err_overflow_q;
  assign err_len      = err_len_q;

  always_ff @(posedge clk) begin
    if (Nrst) begin
      assert (!(df_push && df_full))
        else $error("fsab_sim_mem_v2: data FIFO overflow");
      assert (!(hdr_vld && fsabo_mode && (fsabo_len > LEN_MAX_L)))
        else $error("fsab_sim_mem_v2: write burst longer than LEN_MAX");
      assert (!(fsabi_valid && $isunknown(fsabi_did)))
        else $error("fsab_sim_mem_v2: fsabi_did unknown while fsabi_valid");
    end
  end
endmodule
